// File: rtl/mc_result_stats_if.sv
// Host-side bundle for mc_result_stats: captured inputs from montecarlo/Counter and result outputs.
// std_o exists only when MC_STDERR_EN is defined.
interface mc_result_stats_if #(
  parameter int ACC_W  = 64,
  parameter int M_W    = 32,
  parameter int MEAN_W = 32
);
  logic              mode_i;
  logic              status_i;
  logic [ACC_W-1:0]  sum_i;
  logic [ACC_W-1:0]  sum_square_i;
  logic [M_W-1:0]    m_count_i;
  logic              busy_o;
  logic              valid_o;
  logic [MEAN_W-1:0] mean_o;
  logic [ACC_W-1:0]  variance_o;
  logic              sat_o;
  logic              err_o;
`ifdef MC_STDERR_EN
  logic [31:0]       std_o;
`endif

  modport master (
    output mode_i, status_i, sum_i, sum_square_i, m_count_i,
`ifdef MC_STDERR_EN
    input  std_o,
`endif
    input  busy_o, valid_o, mean_o, variance_o, sat_o, err_o
  );

  modport slave (
    input  mode_i, status_i, sum_i, sum_square_i, m_count_i,
`ifdef MC_STDERR_EN
    output std_o,
`endif
    output busy_o, valid_o, mean_o, variance_o, sat_o, err_o
  );
endinterface

// File: rtl/mc_result_stats.sv
// Mean/variance of Monte Carlo path statistics using one shared sequential restoring divider.
// Optional MC_STDERR_EN adds a digit-by-digit square root stage producing std_o.
module mc_result_stats #(
  parameter int ACC_W  = 64,
  parameter int M_W    = 32,
  parameter int MEAN_W = 32
) (
  input  logic             clk,
  input  logic             nreset,
  mc_result_stats_if.slave bus
);

  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] LAST_DIV  = CNT_W'(ACC_W - 1);
  localparam logic [CNT_W-1:0] LAST_SQRT = CNT_W'(31);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV_MEAN,
    S_DIV_SQ,
    S_VAR,
`ifdef MC_STDERR_EN
    S_SQRT,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              status_prev_q, status_prev_d;
  logic [ACC_W-1:0]  sum_sq_q, sum_sq_d;
  logic [M_W-1:0]    m_q, m_d;
  logic [ACC_W-1:0]  rem_q, rem_d;
  logic [ACC_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MEAN_W-1:0] mean_q, mean_d;
  logic [ACC_W-1:0]  var_q, var_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              sat_q, sat_d;
  logic              err_q, err_d;
`ifdef MC_STDERR_EN
  logic [31:0]       std_q, std_d;
  logic [ACC_W-1:0]  rt_shift;
  logic [ACC_W-1:0]  rt_trial;
  logic              rt_ge;
`endif

  logic              trigger;
  logic [ACC_W:0]    div_m;
  logic [ACC_W:0]    rem_shift;
  logic              div_ge;
  logic [ACC_W-1:0]  div_rem;
  logic [ACC_W-1:0]  div_quo;
  logic              quo_hi_nz;
  logic [2*MEAN_W-1:0] sq;
  logic [ACC_W-1:0]  sq_ext;
  logic [ACC_W-1:0]  var_calc;

  // Shared datapath: one restoring-divider step, the mean^2 product and the clamped difference.
  always_comb begin
    trigger   = bus.status_i & ~status_prev_q & bus.mode_i &
                ((state_q == S_IDLE) || (state_q == S_DONE));
    div_m     = {{(ACC_W + 1 - M_W){1'b0}}, m_q};
    rem_shift = {rem_q, quo_q[ACC_W-1]};
    div_ge    = (rem_shift >= div_m);
    div_rem   = div_ge ? ACC_W'(rem_shift - div_m) : rem_shift[ACC_W-1:0];
    div_quo   = {quo_q[ACC_W-2:0], div_ge};
    quo_hi_nz = |div_quo[ACC_W-1:MEAN_W];
    sq        = {{MEAN_W{1'b0}}, mean_q} * {{MEAN_W{1'b0}}, mean_q};
    sq_ext    = ACC_W'(sq);
    var_calc  = (quo_q >= sq_ext) ? (quo_q - sq_ext) : '0;
`ifdef MC_STDERR_EN
    rt_shift  = {rem_q[ACC_W-3:0], quo_q[ACC_W-1 -: 2]};
    rt_trial  = {{(ACC_W - 34){1'b0}}, std_q, 2'b01};
    rt_ge     = (rt_shift >= rt_trial);
`endif
  end

  always_comb begin
    state_d       = state_q;
    status_prev_d = bus.status_i;
    sum_sq_d      = sum_sq_q;
    m_d           = m_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    cnt_d         = cnt_q;
    mean_d        = mean_q;
    var_d         = var_q;
    busy_d        = busy_q;
    valid_d       = valid_q;
    sat_d         = sat_q;
    err_d         = err_q;
`ifdef MC_STDERR_EN
    std_d         = std_q;
`endif

    // Abort wins over everything, including a trigger in the same cycle.
    if (!bus.mode_i) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      sat_d   = 1'b0;
      err_d   = 1'b0;
      mean_d  = '0;
      var_d   = '0;
`ifdef MC_STDERR_EN
      std_d   = '0;
`endif
    end else if (trigger) begin
      quo_d    = bus.sum_i;
      sum_sq_d = bus.sum_square_i;
      m_d      = bus.m_count_i;
      rem_d    = '0;
      cnt_d    = '0;
      valid_d  = 1'b0;
      sat_d    = 1'b0;
      err_d    = 1'b0;
      busy_d   = 1'b1;
      state_d  = S_DIV_MEAN;
    end else begin
      case (state_q)
        S_DIV_MEAN: begin
          if (m_q == '0) begin
            err_d   = 1'b1;
            mean_d  = '1;
            var_d   = '0;
`ifdef MC_STDERR_EN
            std_d   = '0;
`endif
            state_d = S_DONE;
          end else begin
            rem_d = div_rem;
            quo_d = div_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_DIV) begin
              mean_d  = quo_hi_nz ? {MEAN_W{1'b1}} : div_quo[MEAN_W-1:0];
              sat_d   = quo_hi_nz;
              rem_d   = '0;
              quo_d   = sum_sq_q;
              cnt_d   = '0;
              state_d = S_DIV_SQ;
            end
          end
        end
        S_DIV_SQ: begin
          rem_d = div_rem;
          quo_d = div_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_DIV) begin
            state_d = S_VAR;
          end
        end
        S_VAR: begin
          var_d = var_calc;
`ifdef MC_STDERR_EN
          rem_d   = '0;
          quo_d   = var_calc;
          cnt_d   = '0;
          std_d   = '0;
          state_d = S_SQRT;
`else
          state_d = S_DONE;
`endif
        end
`ifdef MC_STDERR_EN
        S_SQRT: begin
          rem_d = rt_ge ? (rt_shift - rt_trial) : rt_shift;
          quo_d = {quo_q[ACC_W-3:0], 2'b00};
          std_d = {std_q[30:0], rt_ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_SQRT) begin
            state_d = S_DONE;
          end
        end
`endif
        S_DONE: begin
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= S_IDLE;
      status_prev_q <= 1'b0;
      sum_sq_q      <= '0;
      m_q           <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      cnt_q         <= '0;
      mean_q        <= '0;
      var_q         <= '0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      sat_q         <= 1'b0;
      err_q         <= 1'b0;
`ifdef MC_STDERR_EN
      std_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      status_prev_q <= status_prev_d;
      sum_sq_q      <= sum_sq_d;
      m_q           <= m_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      cnt_q         <= cnt_d;
      mean_q        <= mean_d;
      var_q         <= var_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      sat_q         <= sat_d;
      err_q         <= err_d;
`ifdef MC_STDERR_EN
      std_q         <= std_d;
`endif
    end
  end

  assign bus.busy_o     = busy_q;
  assign bus.valid_o    = valid_q;
  assign bus.mean_o     = mean_q;
  assign bus.variance_o = var_q;
  assign bus.sat_o      = sat_q;
  assign bus.err_o      = err_q;
`ifdef MC_STDERR_EN
  assign bus.std_o      = std_q;
`endif

endmodule

// File: tb/tb_mc_result_stats.sv
// Scoreboard bench for mc_result_stats: expected results queued at stimulus, compared on valid_o.
// Honours MC_STDERR_EN for latency and std_o.
module tb_mc_result_stats;

  localparam int ACC_W  = 64;
  localparam int M_W    = 32;
  localparam int MEAN_W = 32;
`ifdef MC_STDERR_EN
  localparam int LATENCY = 162;
`else
  localparam int LATENCY = 130;
`endif

  typedef struct {
    logic [63:0] mean;
    logic [63:0] variance;
    logic [63:0] std_dev;
    logic        sat;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  exp_t exp_q[$];
  int   err_count = 0;
  int   check_count = 0;

  always #5 clk = ~clk;

  mc_result_stats_if #(.ACC_W(ACC_W), .M_W(M_W), .MEAN_W(MEAN_W)) bus_if ();

  mc_result_stats #(.ACC_W(ACC_W), .M_W(M_W), .MEAN_W(MEAN_W)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus_if)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] isqrt(input logic [63:0] v);
    logic [63:0] r;
    logic [63:0] c;
    r = 64'd0;
    for (int b = 31; b >= 0; b--) begin
      c = r | (64'd1 << b);
      if (c * c <= v) r = c;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] m, input logic [63:0] sum, input logic [63:0] sumsq);
    exp_t e;
    logic [63:0] q;
    logic [63:0] e2;
    logic [63:0] sq;
    if (m == 32'd0) begin
      e.mean = 64'hFFFF_FFFF;
      e.variance = 64'd0;
      e.std_dev = 64'd0;
      e.sat = 1'b0;
      e.err = 1'b1;
      e.lat = 2;
    end else begin
      q = sum / {32'd0, m};
      e.sat = (q > 64'hFFFF_FFFF);
      e.mean = e.sat ? 64'hFFFF_FFFF : q;
      e2 = sumsq / {32'd0, m};
      sq = e.mean * e.mean;
      e.variance = (e2 >= sq) ? (e2 - sq) : 64'd0;
      e.std_dev = isqrt(e.variance);
      e.err = 1'b0;
      e.lat = LATENCY;
    end
    return e;
  endfunction

  // Waits for valid_o, scrambling inputs and optionally injecting an ignored trigger meanwhile.
  task automatic collectResult(input bit hold, input bit glitch);
    exp_t e;
    int   k;
    bit   seen;
    seen = 1'b0;
    for (k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("busy_after_capture", {63'd0, bus_if.busy_o}, 64'd1);
        if (!hold) bus_if.status_i = 1'b0;
        bus_if.sum_i        = {$urandom, $urandom};
        bus_if.sum_square_i = {$urandom, $urandom};
        bus_if.m_count_i    = 32'd7;
      end
      if (glitch && !hold && k == 20) bus_if.status_i = 1'b1;
      if (glitch && !hold && k == 21) bus_if.status_i = 1'b0;
      if (bus_if.valid_o) begin
        seen = 1'b1;
        break;
      end
    end
    e = exp_q.pop_front();
    if (!seen) begin
      checkOutput("timeout_valid", 64'd0, 64'd1);
    end else begin
      checkOutput("latency", 64'(k - 1), 64'(e.lat));
      checkOutput("mean", {32'd0, bus_if.mean_o}, e.mean);
      checkOutput("variance", bus_if.variance_o, e.variance);
      checkOutput("sat", {63'd0, bus_if.sat_o}, {63'd0, e.sat});
      checkOutput("err", {63'd0, bus_if.err_o}, {63'd0, e.err});
      checkOutput("busy_at_valid", {63'd0, bus_if.busy_o}, 64'd0);
`ifdef MC_STDERR_EN
      checkOutput("std", {32'd0, bus_if.std_o}, e.std_dev);
`endif
    end
  endtask

  task automatic applyStimulus(input logic [31:0] m, input logic [63:0] sum, input logic [63:0] sumsq,
                               input bit hold, input bit glitch);
    @(negedge clk);
    bus_if.sum_i        = sum;
    bus_if.sum_square_i = sumsq;
    bus_if.m_count_i    = m;
    bus_if.status_i     = 1'b1;
    exp_q.push_back(model(m, sum, sumsq));
    collectResult(hold, glitch);
  endtask

  // Starts a run with no expected result; the caller interrupts it.
  task automatic startOnly(input logic [31:0] m, input logic [63:0] sum, input logic [63:0] sumsq);
    @(negedge clk);
    bus_if.sum_i        = sum;
    bus_if.sum_square_i = sumsq;
    bus_if.m_count_i    = m;
    bus_if.status_i     = 1'b1;
    @(negedge clk);
    bus_if.status_i     = 1'b0;
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_busy"}, {63'd0, bus_if.busy_o}, 64'd0);
    checkOutput({tag, "_valid"}, {63'd0, bus_if.valid_o}, 64'd0);
    checkOutput({tag, "_mean"}, {32'd0, bus_if.mean_o}, 64'd0);
    checkOutput({tag, "_variance"}, bus_if.variance_o, 64'd0);
    checkOutput({tag, "_sat"}, {63'd0, bus_if.sat_o}, 64'd0);
    checkOutput({tag, "_err"}, {63'd0, bus_if.err_o}, 64'd0);
  endtask

  initial begin
    int busy_seen;
    bus_if.mode_i       = 1'b0;
    bus_if.status_i     = 1'b0;
    bus_if.sum_i        = '0;
    bus_if.sum_square_i = '0;
    bus_if.m_count_i    = '0;
    repeat (3) @(negedge clk);
    checkCleared("reset");
    nreset = 1'b1;
    bus_if.mode_i = 1'b1;
    @(negedge clk);
    checkCleared("idle");

    applyStimulus(32'd4, 64'd100, 64'd3000, 1'b0, 1'b0);
    applyStimulus(32'd1, 64'd1 << 40, 64'd1 << 50, 1'b0, 1'b0);
    applyStimulus(32'd1, 64'd10, 64'd20, 1'b0, 1'b0);
    applyStimulus(32'd0, 64'd12345, 64'd999, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus($urandom_range(1, 5000), {24'd0, 8'($urandom_range(0, 255)), $urandom},
                    {$urandom, $urandom}, 1'b0, 1'b1);
    end
    applyStimulus(32'd3, 64'd3_000_000, 64'd3_000_000_000_000, 1'b0, 1'b1);

    // Status held high after completion must not start a second run.
    applyStimulus(32'd4, 64'd100, 64'd3000, 1'b1, 1'b0);
    busy_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus_if.busy_o) busy_seen = 1;
    end
    checkOutput("hold_no_retrigger", 64'(busy_seen), 64'd0);
    checkOutput("hold_valid_kept", {63'd0, bus_if.valid_o}, 64'd1);
    checkOutput("hold_mean_kept", {32'd0, bus_if.mean_o}, 64'd25);
    bus_if.status_i = 1'b0;

    startOnly(32'd4, 64'd100, 64'd3000);
    repeat (50) @(negedge clk);
    checkOutput("busy_mid_div", {63'd0, bus_if.busy_o}, 64'd1);
    bus_if.mode_i = 1'b0;
    @(negedge clk);
    checkCleared("abort");
    bus_if.mode_i = 1'b1;
    applyStimulus(32'd4, 64'd100, 64'd3000, 1'b0, 1'b0);

    startOnly(32'd4, 64'd100, 64'd3000);
    repeat (99) @(negedge clk);
    #2 nreset = 1'b0;
    #1 checkCleared("async_reset");
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    applyStimulus(32'd4, 64'd100, 64'd3000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
